// File: rtl/branch_comp.sv
// RV32I branch comparator: zero-latency equality / less-than flags for the
// control unit, plus a one-cycle registered copy for trace and pipelined reuse.
module branch_comp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             BrUn,
    output logic             Eq,
    output logic             Lt,
    output logic             Eq_q,
    output logic             Lt_q
);

    logic msb_differ;
    logic ult;

    assign Eq         = (data1 == data2);
    assign ult        = (data1 < data2);
    assign msb_differ = data1[WIDTH-1] ^ data2[WIDTH-1];

    // With differing sign bits the negative operand (MSB set) is the smaller
    // one; with matching sign bits signed and unsigned order coincide.
    assign Lt = (!BrUn && msb_differ) ? data1[WIDTH-1] : ult;

    always_ff @(posedge clk) begin
        if (rst) begin
            Eq_q <= 1'b0;
            Lt_q <= 1'b0;
        end else begin
            Eq_q <= Eq;
            Lt_q <= Lt;
        end
    end

endmodule

// File: tb/tb_branch_comp.sv
// Self-checking bench for branch_comp: directed cases followed by a random
// sweep against a plain signed/unsigned reference compare.
module tb_branch_comp;

    logic        clk;
    logic        rst;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        BrUn;
    logic        Eq;
    logic        Lt;
    logic        Eq_q;
    logic        Lt_q;

    int n_checks = 0;
    int n_fail   = 0;

    branch_comp #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .data1 (data1),
        .data2 (data2),
        .BrUn  (BrUn),
        .Eq    (Eq),
        .Lt    (Lt),
        .Eq_q  (Eq_q),
        .Lt_q  (Lt_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_eq(input logic [31:0] a, input logic [31:0] b);
        return a == b;
    endfunction

    function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b, input logic u);
        if (u) return a < b;
        return $signed(a) < $signed(b);
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b (data1=%h data2=%h BrUn=%b rst=%b)",
                   tag, obs, exp, data1, data2, BrUn, rst);
        end
    endtask

    // Drive operands, let them settle without any clock edge, check flags.
    task automatic drive_comb(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic u);
        data1 = a;
        data2 = b;
        BrUn  = u;
        #1;
        check({tag, ".eq"}, Eq, ref_eq(a, b));
        check({tag, ".lt"}, Lt, ref_lt(a, b, u));
    endtask

    // Clock one edge and check the registered flags against what the
    // inputs and reset held at that edge.
    task automatic clock_reg(input string tag);
        logic exp_eq;
        logic exp_lt;
        exp_eq = rst ? 1'b0 : ref_eq(data1, data2);
        exp_lt = rst ? 1'b0 : ref_lt(data1, data2, BrUn);
        @(posedge clk);
        #1;
        check({tag, ".eq_q"}, Eq_q, exp_eq);
        check({tag, ".lt_q"}, Lt_q, exp_lt);
    endtask

    function automatic logic [31:0] pick_operand(input logic [31:0] other);
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            4: v = other ^ 32'h8000_0000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        rst   = 1'b1;
        data1 = 32'd0;
        data2 = 32'd0;
        BrUn  = 1'b0;

        // Reset state of registered flags
        @(posedge clk);
        #1;
        check("reset.eq_q", Eq_q, 1'b0);
        check("reset.lt_q", Lt_q, 1'b0);

        // Equality cases, comb path tracks inputs even under reset
        drive_comb("zero_signed", 32'd0, 32'd0, 1'b0);
        check("zero_signed.eq_const", Eq, 1'b1);
        drive_comb("five_eq_uns", 32'd5, 32'd5, 1'b1);
        check("five_eq_uns.lt_const", Lt, 1'b0);

        // Unsigned compares
        drive_comb("uns_5_10", 32'd5, 32'd10, 1'b1);
        check("uns_5_10.lt_const", Lt, 1'b1);
        drive_comb("uns_15_8", 32'd15, 32'd8, 1'b1);
        drive_comb("uns_ones_1", 32'hFFFF_FFFF, 32'd1, 1'b1);
        check("uns_ones_1.lt_const", Lt, 1'b0);

        // Signed negatives
        drive_comb("sgn_f1_f1", 32'hFFFF_FFF1, 32'hFFFF_FFF1, 1'b0);
        drive_comb("sgn_f2_f1", 32'hFFFF_FFF2, 32'hFFFF_FFF1, 1'b0);
        drive_comb("sgn_f1_f2", 32'hFFFF_FFF1, 32'hFFFF_FFF2, 1'b0);
        check("sgn_f1_f2.lt_const", Lt, 1'b1);

        // Mode sensitivity, BrUn toggle alone with no clock edge
        drive_comb("mix_ones_1_s", 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("mix_ones_1_s.lt_const", Lt, 1'b1);
        BrUn = 1'b1;
        #1;
        check("mix_toggle.lt_const", Lt, 1'b0);
        drive_comb("minmax_s", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        check("minmax_s.lt_const", Lt, 1'b1);
        drive_comb("minmax_u", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        check("minmax_u.lt_const", Lt, 1'b0);

        // Registered flags held in reset while comb Eq is high
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive_comb("rst_hold", 32'd3, 32'd3, 1'b0);
        clock_reg("rst_hold_e1");
        clock_reg("rst_hold_e2");
        check("rst_hold.eq_comb", Eq, 1'b1);
        check("rst_hold.eq_q_const", Eq_q, 1'b0);
        rst = 1'b0;
        clock_reg("rst_release");
        check("rst_release.eq_q_const", Eq_q, 1'b1);
        drive_comb("reg_5_10", 32'd5, 32'd10, 1'b1);
        clock_reg("reg_5_10");
        check("reg_5_10.lt_q_const", Lt_q, 1'b1);
        rst = 1'b1;
        clock_reg("rst_mid");
        check("rst_mid.lt_q_const", Lt_q, 1'b0);
        check("rst_mid.lt_comb", Lt, 1'b1);
        rst = 1'b0;

        // Random sweep
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        u;
            a = ($urandom_range(0, 1) == 0) ? pick_operand(32'd0) : $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = pick_operand(a);
                default: b = $urandom;
            endcase
            u   = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 19) == 0);
            drive_comb("rand", a, b, u);
            check("rand.excl", Eq & Lt, 1'b0);
            clock_reg("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_comp.md
Name: branch_comp

Overview:
- RV32I branch comparator for the single-cycle datapath.
- Compares the two register-file read operands, rs1 on data1 and rs2 on data2.
- Produces equality and less-than flags; the control unit combines these with funct3 to resolve BEQ/BNE/BLT/BGE/BLTU/BGEU.
- Flags are combinational, with zero latency, for same-cycle branch resolution.
- A registered copy of the flags is also provided for trace/debug and for pipelined reuse.

Parameters:
- WIDTH, 32, operand width in bits; must be ≥2.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  reset; synchronous, active-high; affects only the registered flags.
- data1  input  WIDTH  operand A (rs1 value).
- data2  input  WIDTH  operand B (rs2 value).
- BrUn  input  1  1 = unsigned compare; 0 = signed (two's-complement) compare.
- Eq  output  1  combinational: 1 when data1 == data2.
- Lt  output  1  combinational: 1 when data1 < data2 under the mode selected by BrUn.
- Eq_q  output  1  Eq registered on rising edge of clk.
- Lt_q  output  1  Lt registered on rising edge of clk.

Behaviour:
- Eq = (data1 == data2), bitwise over all WIDTH bits; independent of BrUn.
- Lt with BrUn=1: unsigned magnitude compare of data1 and data2.
- Lt with BrUn=0: signed two's-complement compare.
  - If the MSBs differ, Lt = data1[WIDTH-1], i.e. the negative operand is smaller.
  - If the MSBs match, Lt = unsigned compare of the operands.
- Eq and Lt are mutually exclusive: never both 1.
- Lt = 0 whenever Eq = 1, in both modes.
- Eq and Lt are purely combinational.
  - No dependency on clk or rst.
  - They settle within the same cycle as input changes.
  - Any input change, including a BrUn toggle alone, updates them without waiting for a clock edge.
- No X-propagation masking: X/Z on inputs may produce X on outputs.
- Registered path:
  - On each rising clk edge with rst=1: Eq_q ← 0, Lt_q ← 0.
  - On each rising clk edge with rst=0: Eq_q ← Eq, Lt_q ← Lt.
  - Latency is one cycle; there is no enable and no hold.
- Reset asserted mid-operation:
  - Registered flags clear at the next edge.
  - Combinational Eq/Lt keep tracking the inputs during reset.
- The block holds no other state and has no handshake.
- Boundary cases:
  - All-zero operands: Eq=1, Lt=0 in both modes.
  - Signed, most-negative (0x80000000) vs most-positive (0x7FFFFFFF): Lt=1.
  - Unsigned, same operands: Lt=0.
  - All-ones vs zero: signed Lt=1; unsigned Lt=0.

Test Plan:
- data1=0, data2=0, BrUn=0 → Eq=1, Lt=0. Then data1=5, data2=5, BrUn=1 → Eq=1, Lt=0.
- Unsigned compares, BrUn=1:
  - 5 vs 10 → Eq=0, Lt=1.
  - 15 vs 8 → Eq=0, Lt=0.
  - 0xFFFFFFFF vs 0x00000001 → Lt=0.
- Signed negatives, BrUn=0:
  - 0xFFFFFFF1 vs 0xFFFFFFF1 → Eq=1, Lt=0.
  - 0xFFFFFFF2 vs 0xFFFFFFF1 → Eq=0, Lt=0.
  - 0xFFFFFFF1 vs 0xFFFFFFF2 → Eq=0, Lt=1.
- Mixed sign, mode sensitivity:
  - data1=0xFFFFFFFF, data2=1: BrUn=0 → Lt=1; toggle BrUn to 1 with no clock edge → Lt=0 immediately.
  - 0x80000000 vs 0x7FFFFFFF: BrUn=0 → Lt=1; BrUn=1 → Lt=0.
- Registered flags:
  - Hold rst=1 for 2 edges with data1=data2=3 → Eq_q=0, Lt_q=0 while Eq=1.
  - Release rst → Eq_q=1 after the first edge.
  - Apply 5 vs 10, BrUn=1 → Lt_q=1 one edge later.
  - Assert rst mid-stream → Eq_q=Lt_q=0 at the next edge.
- Random sweep: 10k random data1/data2/BrUn, including forced-equal and MSB-boundary values → Eq and Lt match the reference compare and are never both 1; Eq_q/Lt_q equal the previous cycle's Eq/Lt.
